// File: rtl/minivan_pkg.sv
// minivan_pkg: shared types and constants for the minivan serial output stage.
// Optional feature macro: MINIVAN_TX_PARITY_EN (adds an even-parity bit to
// every frame, making it 11 bits long instead of 10).
package minivan_pkg;

  // Transmitter FSM states. The encoding is fixed so that the top level can
  // keep legacy-style logic [2:0] state constants derived from it.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int DATA_BITS = 8;

`ifdef MINIVAN_TX_PARITY_EN
  localparam int FRAME_BITS = 11;  // start + 8 data + parity + stop
`else
  localparam int FRAME_BITS = 10;  // start + 8 data + stop
`endif

endpackage

// File: rtl/minivan_baud_tick.sv
// minivan_baud_tick: bit-period timer for the minivan serial output stage.
// Counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
// clr restarts the bit period so a new frame starts on a full-length start bit.
// Optional feature macro: MINIVAN_TX_PARITY_EN (not used in this file).
module minivan_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Tick only on an enabled cycle so a frozen stage never loses a bit boundary.
  assign tick = ena && (cnt == LAST);

  // Bit-period counter: cleared on frame start, wraps after the last cycle.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ena) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/minivan_uart_tx.sv
// minivan_uart_tx: serializes each accepted result byte as an asynchronous
// 8N1 frame (LSB first, idle high) on the tx pin.
// Optional feature macro: MINIVAN_TX_PARITY_EN -- when defined, an even-parity
// bit is sent between the last data bit and the stop bit (8E1 frame). When it
// is undefined no parity state or parity logic exists at all.
module minivan_uart_tx
  import minivan_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
`ifdef MINIVAN_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = PARITY;
`endif
  localparam logic [2:0] S_STOP   = STOP;
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  logic [2:0]           state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_idx;
  logic                 tick;
  logic                 accept;
`ifdef MINIVAN_TX_PARITY_EN
  logic                 parity_bit;
`endif

  // Handshake: ready depends only on state and enable, never on valid_in,
  // so the upstream cannot form a combinational loop through this stage.
  assign ready_out = (state == S_IDLE) && ena;
  assign busy      = (state != S_IDLE);
  assign accept    = valid_in && ready_out;

  minivan_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .clr  (accept),
    .tick (tick)
  );

  // Frame sequencer: every transition also loads the line level of the state
  // being entered, so tx changes on the same edge as the state.
  // NOTE: tx comes straight from a flop rather than decoded from state, so the
  // serial pin never glitches while the state bits change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shift   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
`ifdef MINIVAN_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (valid_in) begin
            state <= S_START;
            shift <= data_in;
            tx    <= 1'b0;
`ifdef MINIVAN_TX_PARITY_EN
            parity_bit <= ^data_in;
`endif
          end
        end
        S_START: begin
          if (tick) begin
            state   <= S_DATA;
            bit_idx <= '0;
            tx      <= shift[0];
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_IDX) begin
`ifdef MINIVAN_TX_PARITY_EN
              state <= S_PARITY;
              tx    <= parity_bit;
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end
        end
`ifdef MINIVAN_TX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            state <= S_IDLE;
            tx    <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minivan_uart_tx.sv
// tb_minivan_uart_tx: scoreboard bench for minivan_uart_tx. Stimulus pushes
// each accepted byte (with its accept cycle) into a queue; an independent
// monitor recovers frames from tx and compares them with a reference frame
// built from the byte. Optional macro: MINIVAN_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_minivan_uart_tx;

  localparam int CLKS = 4;
`ifdef MINIVAN_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME_CYC = FB * CLKS;
  localparam int PERIOD    = FRAME_CYC + 1;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ena      = 1'b1;
  logic       valid_in = 1'b0;
  logic [7:0] data_in  = 8'h00;
  logic       ready_out;
  logic       tx;
  logic       busy;

  minivan_uart_tx #(.CLKS_PER_BIT(CLKS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic ena_q = 1'b1;
  bit   jitter_on = 1'b0;

  typedef struct {
    logic [7:0] b;
    int         acc;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference frame: bit k of the result is the line level during bit-time k.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef MINIVAN_TX_PARITY_EN
    f[9] = (($countones(b) % 2) == 1);
`endif
    return f;
  endfunction

  // Edge counter and the enable level seen by each edge.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    ena_q <= ena;
  end

  // ---------------- monitor ----------------
  bit          in_frame = 1'b0;
  bit          spur     = 1'b0;
  exp_t        cur;
  int          pos;
  int          wave_err;
  logic [10:0] got;
  logic        prev_tx  = 1'b1;

  task automatic mon_sample();
    logic [10:0] f;
    f = frame_of(cur.b);
    if (tx !== f[pos / CLKS] || busy !== 1'b1 || ready_out !== 1'b0) wave_err++;
    if (pos % CLKS == CLKS / 2) got[pos / CLKS] = tx;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx !== 1'b1) begin
        if (exp_q.size() == 0) begin
          if (!spur) begin
            spur = 1'b1;
            check("unexpected_start", 32'(tx), 32'd1);
          end
        end else begin
          cur      = exp_q.pop_front();
          in_frame = 1'b1;
          pos      = 0;
          wave_err = 0;
          got      = '1;
          check("start_latency", 32'(cyc), 32'(cur.acc));
          mon_sample();
        end
      end
    end else if (ena_q) begin
      pos++;
      if (pos == FRAME_CYC) begin
        in_frame = 1'b0;
        check("frame_bits", 32'(got), 32'(frame_of(cur.b)));
        check("frame_cycle_errs", 32'(wave_err), 32'd0);
        check("post_frame_idle", {29'd0, tx, busy, ready_out}, {29'd0, 1'b1, 1'b0, ena});
      end else begin
        mon_sample();
      end
    end else if (tx !== prev_tx || busy !== 1'b1 || ready_out !== 1'b0) begin
      wave_err++;
    end
    prev_tx = tx;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (jitter_on) ena = ($urandom_range(0, 3) != 0);
  endtask

  // Wait for the handshake on the current data_in/valid_in; returns the
  // accept edge number and records the expected byte.
  task automatic acc_wait(input logic [7:0] byt, output int c);
    c = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ready_out === 1'b1 && valid_in) begin
        tick();
        c = cyc;
        exp_q.push_back('{b: byt, acc: c});
        break;
      end
      tick();
    end
    if (c < 0) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [7:0] byt, input bit keep, output int c);
    data_in  = byt;
    valid_in = 1'b1;
    acc_wait(byt, c);
    if (!keep) valid_in = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((exp_q.size() != 0 || in_frame) && i < 2000) begin
      tick();
      i++;
    end
    check("drain", 32'(exp_q.size()) + 32'(in_frame), 32'd0);
  endtask

  task automatic async_reset_now(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    check(name, {29'd0, tx, busy, ready_out}, {29'd0, 1'b1, 1'b0, 1'b1});
    exp_q.delete();
    repeat (5) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int         a1, a2, a3, n;
    logic [7:0] r;

    // Reset and idle line
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("in_reset", {29'd0, tx, busy, ready_out}, 32'b101);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_idle", {29'd0, tx, busy, ready_out}, 32'b101);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx === 1'b1) n++;
    end
    check("idle_100", 32'(n), 32'd100);
    tick();

    // Single byte
    send(8'hA5, 1'b0, a1);
    drain();

    // Back-to-back with valid held
    send(8'h00, 1'b1, a1);
    send(8'hFF, 1'b0, a2);
    check("b2b_spacing", 32'(a2 - a1), 32'(PERIOD));
    drain();

    // Backpressure: pending byte changes while the stage is busy
    send(8'h5A, 1'b0, a1);
    repeat (6) tick();
    data_in  = 8'h3C;
    valid_in = 1'b1;
    repeat (10) tick();
    data_in = 8'h11;
    acc_wait(8'h11, a2);
    valid_in = 1'b0;
    check("bp_first_idle_accept", 32'(a2 - a1), 32'(PERIOD));
    drain();

    // Asynchronous reset during data bit 3, then a clean frame
    send(8'h0F, 1'b0, a1);
    while (cyc < a1 + CLKS + 3 * CLKS + 2) tick();
    async_reset_now("reset_in_data");
    send(8'h81, 1'b0, a1);
    drain();

    // Asynchronous reset during the start bit (line is low there)
    send(8'hC3, 1'b0, a1);
    check("start_bit_low", 32'(tx), 32'd0);
    async_reset_now("reset_in_start");
    drain();

    // Enable gating during data bit 2, then parity-sensitive bytes
    send(8'h6B, 1'b1, a1);
    while (cyc < a1 + CLKS + 2 * CLKS + 1) tick();
    ena = 1'b0;
    repeat (3) tick();
    check("ena_hold_tx", 32'(tx), 32'(frame_of(8'h6B)[3]));
    repeat (4) tick();
    ena = 1'b1;
    data_in = 8'h07;
    acc_wait(8'h07, a2);
    check("ena_stretch", 32'(a2 - a1), 32'(PERIOD + 7));
    send(8'h03, 1'b0, a3);
    check("frame_period", 32'(a3 - a2), 32'(PERIOD));
    drain();

    // Randomized bytes with random enable stalls and idle gaps
    jitter_on = 1'b1;
    for (int k = 0; k < 30; k++) begin
      r = 8'($urandom);
      send(r, 1'b0, a1);
      repeat ($urandom_range(0, 3)) tick();
    end
    jitter_on = 1'b0;
    ena = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied, %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
